frame_flow_ctrl: RTL and testbench

- Sequences one frame at a time into the 4-line-buffer 3x3 window generator.
- Sits between the capture pixel stream (OV7670 side) and the window generator.
- Meters pixels into the window generator using line credits, so a line buffer is never overwritten before its rows are consumed.
- Latches the per-frame opcode, pads the frame bottom with zero lines, resets the datapath between frames, and reports frame completion.

---
 rtl/frame_flow_ctrl_pkg.sv | 18 +
 rtl/line_credit_counter.sv | 60 ++++++
 rtl/frame_flow_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_frame_flow_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_flow_ctrl_pkg.sv
// Shared definitions for the frame flow controller and the window generator.
// Holds the controller state encoding, the opcode width and the default
// frame geometry used by the window generator.
package frame_flow_ctrl_pkg;

  // Controller states; the encoding is fixed because other blocks decode it.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  localparam int OPCODE_W    = 4;
  localparam int DEF_LINE_W  = 512;
  localparam int DEF_FRAME_H = 480;

endpackage

// File: rtl/line_credit_counter.sv
// Up/down line credit counter with saturation and a sticky error flag.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (credits -> MAX_CREDITS)
//   load      : reload credits to MAX_CREDITS (error flag is not touched)
//   inc       : a consumer finished a line (returns one credit)
//   dec       : a producer completed a line (takes one credit)
//   credits   : current credit count
//   err       : sticky; a credit was returned while already full
module line_credit_counter #(
  parameter int  MAX_CREDITS = 4,
  localparam int CNT_W       = $clog2(MAX_CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] credits,
  output logic             err
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_CREDITS);
  localparam logic [CNT_W-1:0] ZERO = CNT_W'(0);

  // Credit count: simultaneous inc/dec cancel; saturate at FULL and at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= FULL;
    end else if (load) begin
      credits <= FULL;
    end else if (inc && !dec) begin
      if (credits != FULL) begin
        credits <= credits + 1'b1;
      end else begin
        credits <= credits;
      end
    end else if (dec && !inc) begin
      if (credits != ZERO) begin
        credits <= credits - 1'b1;
      end else begin
        credits <= credits;
      end
    end else begin
      credits <= credits;
    end
  end

  // Sticky error: a returned credit while full means the consumer read a
  // line that was never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (inc && (credits == FULL)) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end

endmodule

// File: rtl/frame_flow_ctrl.sv
// Frame flow controller between the capture pixel stream and the 4-line-buffer
// 3x3 window generator. Meters pixels with line credits, latches the frame
// opcode, appends zero padding lines, resets the datapath between frames and
// reports frame completion.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start, i_abort    : begin frame (IDLE only) / abandon current frame
//   i_opcode            : filter opcode, latched on an accepted start
//   i_s_data, i_s_valid : capture pixel stream; o_s_ready is the handshake
//   o_pixel_data(_valid): registered write port into the window generator
//   o_dp_rst            : one-cycle datapath reset pulse
//   i_intr              : window generator finished reading one line
//   o_opcode            : latched opcode
//   o_busy              : controller not idle
//   o_frame_done        : one-cycle end-of-frame pulse
//   o_err               : sticky credit overflow
module frame_flow_ctrl
  import frame_flow_ctrl_pkg::*;
#(
  parameter int LINE_W    = DEF_LINE_W,
  parameter int FRAME_H   = DEF_FRAME_H,
  parameter int PAD_LINES = 2,
  parameter int LINE_BUFS = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [7:0]          i_s_data,
  input  logic                i_s_valid,
  output logic                o_s_ready,
  output logic [7:0]          o_pixel_data,
  output logic                o_pixel_data_valid,
  output logic                o_dp_rst,
  input  logic                i_intr,
  output logic [OPCODE_W-1:0] o_opcode,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic                o_err
);

  localparam int PIX_W  = $clog2(LINE_W);
  localparam int LINE_CW = $clog2(FRAME_H + PAD_LINES + 1);
  localparam int CRED_W = $clog2(LINE_BUFS + 1);

  localparam logic [PIX_W-1:0]   PIX_LAST  = PIX_W'(LINE_W - 1);
  localparam logic [LINE_CW-1:0] LAST_IN   = LINE_CW'(FRAME_H - 1);
  localparam logic [LINE_CW-1:0] LAST_PAD  = LINE_CW'(FRAME_H + PAD_LINES - 1);
  // The window generator lags two lines behind (3-row window), so the last
  // two padded lines never produce their own read-complete interrupt.
  localparam logic [LINE_CW-1:0] DONE_LINE = LINE_CW'(FRAME_H + PAD_LINES - 2);

  state_t             state;
  state_t             next_state;
  logic [PIX_W-1:0]   pix_cnt;
  logic [LINE_CW-1:0] line_in;
  logic [LINE_CW-1:0] line_out;
  logic [CRED_W-1:0]  credits;
  logic               start_ok;
  logic               abort_ok;
  logic               write_en;
  logic               line_done;
  logic               intr_en;

  assign o_busy    = (state != ST_IDLE);
  assign o_s_ready = (state == ST_STREAM) && (credits != CRED_W'(0));

  // Handshake and counter event decode.
  always_comb begin
    start_ok  = 1'b0;
    abort_ok  = 1'b0;
    write_en  = 1'b0;
    intr_en   = 1'b0;
    line_done = 1'b0;
    if (state == ST_IDLE) begin
      start_ok = i_start;
    end else begin
      abort_ok = i_abort;
      intr_en  = i_intr;
      // An aborting cycle writes nothing, so the pending pixel is dropped.
      if (!i_abort) begin
        if (state == ST_STREAM) begin
          write_en = i_s_valid && o_s_ready;
        end else if (state == ST_FLUSH) begin
          write_en = (credits != CRED_W'(0));
        end else begin
          write_en = 1'b0;
        end
      end else begin
        write_en = 1'b0;
      end
    end
    line_done = write_en && (pix_cnt == PIX_LAST);
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (i_start) next_state = ST_STREAM;
        else         next_state = ST_IDLE;
      end
      ST_STREAM: begin
        if (line_done && (line_in == LAST_IN))
          next_state = (PAD_LINES == 0) ? ST_DRAIN : ST_FLUSH;
        else
          next_state = ST_STREAM;
      end
      ST_FLUSH: begin
        if (line_done && (line_in == LAST_PAD)) next_state = ST_DRAIN;
        else                                    next_state = ST_FLUSH;
      end
      ST_DRAIN: begin
        if (line_out == DONE_LINE) next_state = ST_IDLE;
        else                       next_state = ST_DRAIN;
      end
      default: next_state = ST_IDLE;
    endcase
    if (abort_ok) begin
      next_state = ST_IDLE;
    end else begin
      next_state = next_state;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Pulse outputs and the latched opcode.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dp_rst     <= 1'b0;
      o_frame_done <= 1'b0;
      o_opcode     <= {OPCODE_W{1'b0}};
    end else begin
      o_dp_rst     <= start_ok || abort_ok;
      o_frame_done <= (state == ST_DRAIN) && !abort_ok && (line_out == DONE_LINE);
      if (start_ok) o_opcode <= i_opcode;
      else          o_opcode <= o_opcode;
    end
  end

  // Registered pixel path; padding lines write zeros, data holds when idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pixel_data       <= 8'h00;
      o_pixel_data_valid <= 1'b0;
    end else begin
      o_pixel_data_valid <= write_en;
      if (write_en) o_pixel_data <= (state == ST_STREAM) ? i_s_data : 8'h00;
      else          o_pixel_data <= o_pixel_data;
    end
  end

  // Pixel and line counters, cleared when a frame starts.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pix_cnt  <= PIX_W'(0);
      line_in  <= LINE_CW'(0);
      line_out <= LINE_CW'(0);
    end else if (start_ok) begin
      pix_cnt  <= PIX_W'(0);
      line_in  <= LINE_CW'(0);
      line_out <= LINE_CW'(0);
    end else begin
      if (write_en) pix_cnt <= (pix_cnt == PIX_LAST) ? PIX_W'(0) : pix_cnt + 1'b1;
      else          pix_cnt <= pix_cnt;
      if (line_done) line_in <= line_in + 1'b1;
      else           line_in <= line_in;
      if (intr_en) line_out <= line_out + 1'b1;
      else         line_out <= line_out;
    end
  end

  line_credit_counter #(
    .MAX_CREDITS(LINE_BUFS)
  ) u_credits (
    .clk    (i_clk),
    .rst    (i_rst),
    .load   (start_ok),
    .inc    (intr_en),
    .dec    (line_done),
    .credits(credits),
    .err    (o_err)
  );

endmodule

// File: tb/tb_frame_flow_ctrl.sv
module tb_frame_flow_ctrl;

  localparam int LW = 8;
  localparam int FH = 6;
  localparam int PL = 2;
  localparam int LB = 4;
  localparam int DATA_PX   = LW * FH;
  localparam int TOTAL_PX  = LW * (FH + PL);
  localparam int DONE_LINE = FH + PL - 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       s_valid = 1'b0;
  logic       intr = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready, pixel_valid, dp_rst, busy, frame_done, err;
  logic [7:0] pixel_data;
  logic [3:0] opcode_out;

  always #5 clk = ~clk;

  frame_flow_ctrl #(.LINE_W(LW), .FRAME_H(FH), .PAD_LINES(PL), .LINE_BUFS(LB)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_opcode(opcode),
    .i_s_data(s_data), .i_s_valid(s_valid), .o_s_ready(s_ready),
    .o_pixel_data(pixel_data), .o_pixel_data_valid(pixel_valid), .o_dp_rst(dp_rst),
    .i_intr(intr), .o_opcode(opcode_out), .o_busy(busy), .o_frame_done(frame_done),
    .o_err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int cnt_acc = 0, cnt_wr = 0, cnt_dp = 0, cnt_fd = 0;
  int due[$];

  // Reference model: a frame is a pixel count walking 0..TOTAL_PX; credits are
  // LINE_BUFS minus lines written plus lines read, capped at LINE_BUFS.
  bit         m_busy = 1'b0;
  int         m_emit = 0;
  int         m_cred = LB;
  int         m_lout = 0;
  bit         m_err  = 1'b0;
  logic [3:0] e_op = 4'h0;
  logic [7:0] e_pd = 8'h00;
  bit         e_pv = 1'b0, e_dp = 1'b0, e_fd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_step(input logic r, input logic st, input logic ab, input logic v,
                            input logic [7:0] d, input logic it, input logic [3:0] op);
    bit wr;
    int ld;
    e_dp = 1'b0; e_fd = 1'b0; e_pv = 1'b0;
    if (r) begin
      m_busy = 1'b0; m_emit = 0; m_cred = LB; m_lout = 0; m_err = 1'b0;
      e_op = 4'h0; e_pd = 8'h00;
    end else if (!m_busy) begin
      if (st) begin
        m_busy = 1'b1; e_op = op; e_dp = 1'b1;
        m_emit = 0; m_cred = LB; m_lout = 0;
      end
    end else begin
      wr = 1'b0;
      if (!ab) begin
        if (m_emit < DATA_PX)       wr = v && (m_cred != 0);
        else if (m_emit < TOTAL_PX) wr = (m_cred != 0);
      end
      if (ab) begin
        m_busy = 1'b0; e_dp = 1'b1;
      end else if (m_emit == TOTAL_PX && m_lout == DONE_LINE) begin
        m_busy = 1'b0; e_fd = 1'b1;
      end
      ld = 0;
      if (wr) begin
        e_pv = 1'b1;
        e_pd = (m_emit < DATA_PX) ? d : 8'h00;
        m_emit++;
        if (m_emit % LW == 0) ld = 1;
      end
      if (it) begin
        if (m_cred == LB) m_err = 1'b1;
        m_lout++;
      end
      m_cred = m_cred - ld + (it ? 1 : 0);
      if (m_cred > LB) m_cred = LB;
    end
  endtask

  task automatic cycle(input logic r, input logic st, input logic ab, input logic v,
                       input logic [7:0] d, input logic it, input logic [3:0] op);
    logic acc;
    rst = r; start = st; abort = ab; s_valid = v; s_data = d; intr = it; opcode = op;
    acc = v && (s_ready === 1'b1) && !r;
    @(posedge clk);
    model_step(r, st, ab, v, d, it, op);
    #1;
    cyc++;
    if (acc) cnt_acc++;
    if (pixel_valid === 1'b1) cnt_wr++;
    if (dp_rst === 1'b1) cnt_dp++;
    if (frame_done === 1'b1) cnt_fd++;
    chk("busy",       32'(busy),        32'(m_busy));
    chk("s_ready",    32'(s_ready),     32'(m_busy && m_emit < DATA_PX && m_cred != 0));
    chk("pix_valid",  32'(pixel_valid), 32'(e_pv));
    chk("pix_data",   32'(pixel_data),  32'(e_pd));
    chk("dp_rst",     32'(dp_rst),      32'(e_dp));
    chk("frame_done", 32'(frame_done),  32'(e_fd));
    chk("opcode",     32'(opcode_out),  32'(e_op));
    chk("err",        32'(err),         32'(m_err));
  endtask

  task automatic begin_frame(input logic [3:0] op);
    cnt_acc = 0; cnt_wr = 0; cnt_dp = 0; cnt_fd = 0;
    due.delete();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, op);
  endtask

  // vmode: 0 continuous, 1 alternating, 2 random valid (with start noise)
  // imode: 0 none, 1 read 20 cycles after each line from the 3rd,
  //        2 random reads lagging two lines, 3 read on stall plus one read
  //        coinciding with the last pixel of line 5
  task automatic run(input int vmode, input int imode, input int abort_at,
                     input int ncyc, input bit until_idle);
    int   prev;
    logic v, it, ab, st;
    for (int n = 0; n < ncyc; n++) begin
      if (until_idle && !m_busy) break;
      case (vmode)
        0:       v = 1'b1;
        1:       v = (n % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      st = (vmode == 2) && ($urandom_range(0, 15) == 0);
      it = 1'b0;
      if (imode == 1) begin
        if (due.size() > 0 && due[0] <= cyc + 1) begin
          it = 1'b1;
          void'(due.pop_front());
        end
      end else if (imode == 2) begin
        it = (m_lout < m_emit / LW - 2) && ($urandom_range(0, 3) == 0);
      end else if (imode == 3) begin
        it = (m_emit == 39 && v) ||
             (m_cred == 0 && m_lout < m_emit / LW - 2) ||
             (m_emit == TOTAL_PX && m_lout < DONE_LINE);
      end
      ab = (abort_at >= 0) && (m_emit == abort_at);
      prev = m_emit / LW;
      cycle(1'b0, st, ab, v, 8'($urandom), it, 4'($urandom));
      if (imode == 1 && m_emit / LW != prev && m_emit / LW >= 3) due.push_back(cyc + 20);
    end
    if (until_idle) chk("frame_end_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);

    // Basic frame
    begin_frame(4'h3);
    run(0, 1, -1, 600, 1'b1);
    chk("basic_accepted", 32'(cnt_acc), 32'd48);
    chk("basic_writes",   32'(cnt_wr),  32'd64);
    chk("basic_dp_rst",   32'(cnt_dp),  32'd1);
    chk("basic_done",     32'(cnt_fd),  32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'h0);  // read pulse while idle is ignored

    // Backpressure
    begin_frame(4'h9);
    run(0, 0, -1, 60, 1'b0);
    chk("bp_accept_32", 32'(cnt_acc), 32'd32);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 4'h0);
    run(0, 0, -1, 40, 1'b0);
    chk("bp_accept_40", 32'(cnt_acc), 32'd40);
    run(2, 2, -1, 800, 1'b1);

    // Read-complete coincident with the last pixel of line 5
    begin_frame(4'h5);
    run(0, 3, -1, 600, 1'b1);
    chk("simul_accepted", 32'(cnt_acc), 32'd48);
    chk("simul_writes",   32'(cnt_wr),  32'd64);

    // Alternating valid
    begin_frame(4'hA);
    run(1, 2, -1, 800, 1'b1);
    chk("gap_accepted", 32'(cnt_acc), 32'd48);
    chk("gap_writes",   32'(cnt_wr),  32'd64);

    // Abort mid line 3, then a clean frame
    begin_frame(4'h6);
    run(0, 2, 20, 200, 1'b1);
    chk("abort_no_done", 32'(cnt_fd), 32'd0);
    chk("abort_dp_rst",  32'(cnt_dp), 32'd2);
    begin_frame(4'h7);
    run(2, 2, -1, 800, 1'b1);
    chk("after_abort_done",   32'(cnt_fd), 32'd1);
    chk("after_abort_writes", 32'(cnt_wr), 32'd64);

    // Error flag and reset mid-stream
    begin_frame(4'hC);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'h0);
    chk("err_set", 32'(err), 32'd1);
    run(0, 0, -1, 15, 1'b0);
    chk("err_sticky", 32'(err), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 4'h0);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    begin_frame(4'h1);
    run(0, 0, -1, 50, 1'b0);
    chk("rst_credits_32", 32'(cnt_acc), 32'd32);
    run(2, 2, -1, 800, 1'b1);

    // Random frames, one with a random abort point
    for (int f = 0; f < 4; f++) begin
      begin_frame(4'($urandom));
      run(2, 2, (f == 2) ? int'($urandom_range(0, 63)) : -1, 900, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
